tcdm_bank_rr_arbiter: RTL
=========================

// Module: tcdm_bank_rr_arbiter
// PURPOSE
//  Shares one single-ported TCDM SRAM bank between NumIn requesting ports with fair round-robin arbitration.
//  Muxes the winner's address/wen/wdata/be onto the bank port and returns a valid response exactly one cycle
//  after each grant. Sits between the master side of the TCDM interconnect and one bank; one instance per bank.
// PARAMETERS
//  NumIn       4    number of requesting ports (>=1, need not be a power of 2)
//  DataWidth   32   data word width in bits, multiple of 8
//  AddrWidth   10   bank word-address width (MemAddrBits)
//  RespLat     1    fixed bank read latency in cycles; only 1 is supported (elaboration $fatal otherwise)
// PORTS
//  clk_i      in   1                    clock
//  rst_ni     in   1                    asynchronous active-low reset
//  req_i      in   NumIn                per-port request
//  add_i      in   NumIn x AddrWidth    per-port bank word address
//  wen_i      in   NumIn                per-port write enable (1=write)
//  wdata_i    in   NumIn x DataWidth    per-port write data
//  be_i       in   NumIn x DataWidth/8  per-port byte enables
//  gnt_o      out  NumIn                per-port grant (combinational, one-hot or zero)
//  vld_o      out  NumIn                per-port response valid, one cycle after grant
//  rdata_o    out  NumIn x DataWidth    response data, bank rdata broadcast to all ports
//  req_o      out  1                    bank chip select
//  gnt_i      in   1                    bank ready; tie to req_o for an always-ready SRAM
//  add_o      out  AddrWidth            bank address of winner
//  wen_o      out  1                    bank write enable of winner
//  wdata_o    out  DataWidth            bank write data of winner
//  be_o       out  DataWidth/8          bank byte enables of winner
//  conflict_o out  1                    pulse: >1 request active in a cycle where a grant occurs
// BEHAVIOUR
//  - State: rr_q (clog2(NumIn) bits, NumIn=1 -> 1 bit held 0), vld_q (NumIn). Async reset: rr_q=0, vld_q=0.
//  - Reset values: req_o=0 and gnt_o=0 while rst_ni=0 (requests ignored), vld_o=0, conflict_o=0.
//    add_o/wen_o/wdata_o/be_o are don't-care while req_o=0.
//  - Arbitration (combinational): winner w = first k with req_i[k]=1, scanning rr_q, rr_q+1, ... mod NumIn.
//  - Bank port: req_o = |req_i; add_o/wen_o/wdata_o/be_o = port w.
//  - Grant: gnt_o[w] = req_o & gnt_i. All other gnt_o bits are 0. gnt_o never depends on wen_i.
//  - Pointer update: on req_o & gnt_i, rr_q <= (w==NumIn-1) ? 0 : w+1. Explicit wrap, no power-of-2 modulo.
//    Otherwise rr_q holds. No request or a bank stall (gnt_i=0) does not move the pointer.
//  - Response: vld_q <= gnt_o each cycle; vld_o = vld_q. Issued for reads AND writes, so every grant gives
//    exactly one vld. rdata_o[k] = bank rdata (registered by the bank) for every k; consumers qualify it with vld_o.
//  - Back-to-back: a port may be granted in consecutive cycles; its vld_o stays high for each following cycle.
//  - Ungranted requesters must hold req_i and payload stable. The arbiter keeps no pending state of its own.
//  - Fairness: with all NumIn ports requesting continuously and gnt_i=1, each port is granted once per NumIn cycles.
//  - conflict_o = (popcount(req_i)>1) & req_o & gnt_i.
//  - Reset mid-operation: vld_q clears asynchronously, so an in-flight response is dropped and not replayed.
//    rr_q returns to 0.
// STRUCTURE
//  - Shared package tcdm_arb_pkg: typedefs for req/resp payload structs (addr, wen, wdata, be), and the
//    function rr_next(idx, n) with explicit wrap.
//  - One combinational sub-module tcdm_rr_pick: inputs req vector and start pointer; outputs one-hot grant,
//    binary index and a valid flag; implemented as a rotate / leading-one / unrotate.
//  - Top: tcdm_rr_pick, payload mux, rr_q/vld_q flops, conflict logic.
// TESTING
//  1. Reset with req_i=4'b1111 held -> gnt_o=0, vld_o=0. After release with gnt_i=1: grants 0,1,2,3,0 in
//     cycles 1..5, each vld_o one cycle later.
//  2. NumIn=3, all requesting for 9 cycles -> each port granted exactly 3 times. Pointer wraps 2->0, never reaches 3.
//  3. Write then read: port1 writes 32'hDEADBEEF with be=4'b0011 to addr 5 (old value 32'h12345678), then
//     port2 reads addr 5 -> rdata_o=32'h1234BEEF with vld_o[2]=1 one cycle after gnt_o[2]. Write also yields vld_o[1].
//  4. gnt_i=0 for 3 cycles with req_i=4'b0110 -> gnt_o=0 and rr_q holds.
//     When gnt_i=1, port 1 is granted first, then port 2. conflict_o=1 only in granted cycles.
//  5. Assert rst_ni low for one cycle right after a grant to port 3 -> vld_o[3] stays 0, rr_q=0 after release.
//  6. Random traffic at p=0.25/0.5/1.0 on 8 ports against a memory model -> every gnt followed by vld with
//     matching data. No two gnt_o bits high at once. Max wait per port <= NumIn-1 grant cycles.

Source files
------------

// File: rtl/tcdm_arb_pkg.sv
// Shared types and helpers for the TCDM bank round-robin arbiter.
package tcdm_arb_pkg;

  // Default bank geometry; masters using the standard bank size can use these payload types directly.
  localparam int unsigned TcdmAddrWidth = 10;
  localparam int unsigned TcdmDataWidth = 32;

  typedef struct packed {
    logic [TcdmAddrWidth-1:0]   addr;
    logic                       wen;
    logic [TcdmDataWidth-1:0]   wdata;
    logic [TcdmDataWidth/8-1:0] be;
  } tcdm_req_t;

  typedef struct packed {
    logic                     vld;
    logic [TcdmDataWidth-1:0] rdata;
  } tcdm_resp_t;

  // Pointer advance with an explicit wrap so non power-of-2 port counts never overrun.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tcdm_rr_pick.sv
// Combinational round-robin picker: rotate by the start pointer, take the first
// requester, then map the offset back to an absolute port index.
module tcdm_rr_pick #(
  parameter int unsigned NumIn = 4,
  parameter int unsigned IdxW  = 2
) (
  input  logic [NumIn-1:0] req_i,
  input  logic [IdxW-1:0]  start_i,
  output logic [NumIn-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             vld_o
);

  localparam logic [IdxW:0] NumInW = (IdxW+1)'(NumIn);

  logic [2*NumIn-1:0] w_req_dbl;
  logic [NumIn-1:0]   w_req_rot;
  logic [IdxW-1:0]    w_off;
  logic [IdxW:0]      w_sum;

  // rotate so the port at the start pointer sits at bit 0
  assign w_req_dbl = {req_i, req_i};
  assign w_req_rot = NumIn'(w_req_dbl >> start_i);

  // lowest set bit of the rotated vector is the distance from the start pointer
  always_comb begin
    w_off = '0;
    for (int k = int'(NumIn) - 1; k >= 0; k--) begin
      if (w_req_rot[k]) w_off = IdxW'(k);
    end
  end

  // unrotate with an explicit subtract-wrap rather than a power-of-2 modulo
  always_comb begin
    w_sum = {1'b0, start_i} + {1'b0, w_off};
    idx_o = IdxW'((w_sum >= NumInW) ? (w_sum - NumInW) : w_sum);
  end

  assign vld_o = |req_i;
  assign gnt_o = vld_o ? (NumIn'(1) << idx_o) : '0;

endmodule

// File: rtl/tcdm_bank_rr_arbiter.sv
// Round-robin arbiter sharing one single-ported TCDM bank among NumIn masters.
// Each grant produces exactly one response valid on the following cycle.
module tcdm_bank_rr_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned RespLat   = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumIn-1:0]                      req_i,
  input  logic [NumIn-1:0][AddrWidth-1:0]       add_i,
  input  logic [NumIn-1:0]                      wen_i,
  input  logic [NumIn-1:0][DataWidth-1:0]       wdata_i,
  input  logic [NumIn-1:0][DataWidth/8-1:0]     be_i,
  output logic [NumIn-1:0]                      gnt_o,
  output logic [NumIn-1:0]                      vld_o,
  output logic [NumIn-1:0][DataWidth-1:0]       rdata_o,
  output logic                                  req_o,
  input  logic                                  gnt_i,
  output logic [AddrWidth-1:0]                  add_o,
  output logic                                  wen_o,
  output logic [DataWidth-1:0]                  wdata_o,
  output logic [DataWidth/8-1:0]                be_o,
  input  logic [DataWidth-1:0]                  rdata_i,
  output logic                                  conflict_o
);

  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned BeW  = DataWidth / 8;

  if (RespLat != 1) begin : g_bad_lat
    $fatal(1, "tcdm_bank_rr_arbiter: only RespLat=1 is supported");
  end
  if (NumIn < 1) begin : g_bad_num
    $fatal(1, "tcdm_bank_rr_arbiter: NumIn must be at least 1");
  end
  if ((DataWidth % 8) != 0) begin : g_bad_dw
    $fatal(1, "tcdm_bank_rr_arbiter: DataWidth must be a multiple of 8");
  end

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 wen;
    logic [DataWidth-1:0] wdata;
    logic [BeW-1:0]       be;
  } payload_t;

  logic [IdxW-1:0]  r_rr;
  logic [NumIn-1:0] r_vld;

  logic [NumIn-1:0] w_pick_oh;
  logic [IdxW-1:0]  w_idx;
  logic             w_any;
  logic             w_fire;
  logic             w_multi;
  payload_t         w_pl;

  tcdm_rr_pick #(
    .NumIn (NumIn),
    .IdxW  (IdxW)
  ) u_pick (
    .req_i   (req_i),
    .start_i (r_rr),
    .gnt_o   (w_pick_oh),
    .idx_o   (w_idx),
    .vld_o   (w_any)
  );

  // requests are ignored while reset is held so nothing reaches the bank
  assign req_o   = rst_ni & w_any;
  assign w_fire  = req_o & gnt_i;
  assign gnt_o   = w_fire ? w_pick_oh : '0;

  // clearing the lowest set bit leaves something only when two or more ports request
  assign w_multi    = |(req_i & (req_i - NumIn'(1)));
  assign conflict_o = w_multi & w_fire;

  // AND-OR payload mux steered by the one-hot winner
  always_comb begin
    w_pl = '0;
    for (int k = 0; k < int'(NumIn); k++) begin
      if (w_pick_oh[k]) begin
        w_pl.addr  = add_i[k];
        w_pl.wen   = wen_i[k];
        w_pl.wdata = wdata_i[k];
        w_pl.be    = be_i[k];
      end
    end
  end

  assign add_o   = w_pl.addr;
  assign wen_o   = w_pl.wen;
  assign wdata_o = w_pl.wdata;
  assign be_o    = w_pl.be;

  // bank read data is registered by the bank; every port sees it and qualifies with vld_o
  assign rdata_o = {NumIn{rdata_i}};

  // pointer moves past the winner only on an accepted grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_rr <= '0;
    else if (w_fire) r_rr <= IdxW'(rr_next(32'(w_idx), NumIn));
  end

  // response valid trails the grant by one cycle; reset drops anything in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_vld <= '0;
    else         r_vld <= gnt_o;
  end

  assign vld_o = r_vld;

endmodule
